memory_stage_pipe: RTL and testbench
====================================

MEMORY_STAGE_PIPE -- requirements
Module: memory_stage_pipe

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
- DATA_W, 16, data and ALU result width.
- ADDR_W, 16, address width.
- DEPTH, 256, data-memory words; power of two, 2..2^ADDR_W.
- READ_LAT, 1, read latency in cycles, legal 1..4.

REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on its rising edge.
- reset, in, 1, synchronous, active-high.
- in_valid, in, 1, upstream presents an operation.
- in_ready, out, 1, block can accept an operation.
- MemReadM, in, 1, load request.
- MemWriteM, in, 1, store request.
- addrM, in, ADDR_W, word address.
- write_dataM, in, DATA_W, store data.
- alu_resultM, in, DATA_W, ALU result to forward.
- out_valid, out, 1, result available.
- out_ready, in, 1, downstream accepts the result.
- MemReadDataW, out, DATA_W, load data.
- alu_resultW, out, DATA_W, forwarded ALU result.
- access_err, out, 1, address out of range for the accepted operation.

Function
REQ-003 Storage SHALL be DEPTH x DATA_W words, not cleared by reset.
REQ-004 FSM SHALL have three states:
- IDLE: in_ready=1.
- BUSY: load latency counting.
- HOLD: out_valid=1, waiting for out_ready.
REQ-005 in_ready SHALL be 1 only in IDLE; an operation is accepted at the edge where in_valid & in_ready.
REQ-006 At accept, addrM, alu_resultM and the op type SHALL be captured; inputs are don't-care afterwards.
REQ-007 MemWriteM=1 SHALL be a store; MemReadM SHALL be ignored when both are set.
REQ-008 A store SHALL write mem[addrM] at the accept edge, then move to HOLD.
- MemReadDataW = 0 for a store.
- out_valid rises the next cycle.
REQ-009 Neither flag set SHALL be a pass-through: go to HOLD at the accept edge, MemReadDataW = 0.
REQ-010 A load SHALL assert out_valid exactly READ_LAT cycles after the accept edge.
- READ_LAT=1: capture mem[addr] at the accept edge and go to HOLD.
- READ_LAT>1: go to BUSY with counter = READ_LAT-2; decrement each edge; on the edge where counter = 0, capture mem[addr] and go to HOLD.
REQ-011 Load data SHALL reflect every store accepted earlier; read-after-write to the same address needs no extra delay.
REQ-012 Addresses >= DEPTH SHALL set access_err=1 for that result.
- Store is suppressed (memory unchanged).
- Load returns MemReadDataW = 0 with normal latency.
REQ-013 In HOLD, MemReadDataW, alu_resultW and access_err SHALL be stable; out_ready=1 returns the FSM to IDLE at that edge.
REQ-014 in_ready SHALL remain 0 during the cycle in which HOLD is exited; accept is possible from the following cycle, so minimum spacing is 2 cycles per store or pass-through.
REQ-015 alu_resultW SHALL equal the captured alu_resultM for every op type.
REQ-016 out_valid SHALL not drop while in HOLD until out_ready=1, for any duration of out_ready=0.

Reset
REQ-017 reset=1 at a rising edge SHALL force IDLE and clear the counter.
- Outputs: out_valid=0, MemReadDataW=0, alu_resultW=0, access_err=0.
- in_ready=1 from the next cycle.
REQ-018 Reset during BUSY or HOLD SHALL discard the pending result without emitting out_valid; a store already written is not undone.
REQ-019 Reset SHALL have priority over a simultaneous in_valid; that operation is not accepted.

Verification
REQ-020 Store then load, READ_LAT=1:
- Stimulus: store 0xBEEF to 0x0010; load 0x0010.
- Response: load out_valid 1 cycle after accept, MemReadDataW=0xBEEF.
REQ-021 READ_LAT=3, DEPTH=256:
- Stimulus: load 0x0020 after storing 0x1234 there.
- Response: out_valid exactly 3 cycles after accept, data 0x1234.
REQ-022 Backpressure:
- Stimulus: hold out_ready=0 for 5 cycles after out_valid.
- Response: outputs stable, in_ready=0 throughout; IDLE one cycle after out_ready=1.
REQ-023 Out of range, DEPTH=256:
- Stimulus: store 0x5555 to 0x0100, then load 0x0000.
- Response: access_err=1 on the store result; mem[0] unchanged.
REQ-024 Pass-through:
- Stimulus: neither flag set, alu_resultM=0x00A5.
- Response: alu_resultW=0x00A5, MemReadDataW=0, access_err=0.
REQ-025 Reset during BUSY, READ_LAT=4:
- Stimulus: assert reset 1 cycle after load accept.
- Response: no out_valid; in_ready=1 the cycle after reset is released.

Source files
------------

// File: rtl/memory_stage_pipe_if.sv
// Operand/result bundle between the execute side and the memory stage.
// The slave modport is the memory stage's view; master is the driver's view.
interface memory_stage_pipe_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic              MemReadM;
    logic              MemWriteM;
    logic [ADDR_W-1:0] addrM;
    logic [DATA_W-1:0] write_dataM;
    logic [DATA_W-1:0] alu_resultM;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] MemReadDataW;
    logic [DATA_W-1:0] alu_resultW;
    logic              access_err;

    modport slave (
        input  in_valid, MemReadM, MemWriteM, addrM, write_dataM, alu_resultM, out_ready,
        output in_ready, out_valid, MemReadDataW, alu_resultW, access_err
    );

    modport master (
        output in_valid, MemReadM, MemWriteM, addrM, write_dataM, alu_resultM, out_ready,
        input  in_ready, out_valid, MemReadDataW, alu_resultW, access_err
    );
endinterface

// File: rtl/memory_stage_pipe.sv
// Memory stage: single-outstanding load/store/pass-through with configurable read latency
// and a held result until the downstream stage accepts it.
module memory_stage_pipe #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned READ_LAT = 1
) (
    input logic                clk,
    input logic                reset,
    memory_stage_pipe_if.slave bus
);
    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam int unsigned CNT_INIT = (READ_LAT > 1) ? READ_LAT - 2 : 0;

    typedef enum logic [1:0] {StIdle, StBusy, StHold} state_e;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  addr_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] alu_q;
    logic              err_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic             accept;
    logic             is_store;
    logic             is_load;
    logic             in_range;
    logic             load_fire;
    logic [IDX_W-1:0] idx;

    // Reset wins over a simultaneous request, so it also gates the accept strobe.
    assign accept    = bus.in_valid && (state_q == StIdle) && !reset;
    assign is_store  = bus.MemWriteM;
    assign is_load   = bus.MemReadM && !bus.MemWriteM;
    assign in_range  = {1'b0, bus.addrM} < (ADDR_W + 1)'(DEPTH);
    assign idx       = bus.addrM[IDX_W-1:0];
    assign load_fire = (state_q == StBusy) && (cnt_q == 2'd0);

    assign bus.in_ready     = (state_q == StIdle);
    assign bus.out_valid    = (state_q == StHold);
    assign bus.MemReadDataW = rdata_q;
    assign bus.alu_resultW  = alu_q;
    assign bus.access_err   = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_load && (READ_LAT > 1)) begin
                        state_d = StBusy;
                        cnt_d   = 2'(CNT_INIT);
                    end else begin
                        state_d = StHold;
                    end
                end
            end
            StBusy: begin
                if (cnt_q == 2'd0) begin
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Storage is deliberately left out of reset; out-of-range stores are dropped.
    always_ff @(posedge clk) begin
        if (accept && is_store && in_range) begin
            mem[idx] <= bus.write_dataM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
            alu_q   <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
        end else if (accept) begin
            alu_q   <= bus.alu_resultM;
            err_q   <= !in_range;
            addr_q  <= idx;
            rdata_q <= (is_load && (READ_LAT == 1) && in_range) ? mem[idx] : '0;
        end else if (load_fire) begin
            rdata_q <= err_q ? '0 : mem[addr_q];
        end
    end
endmodule

// File: tb/tb_memory_stage_pipe.sv
// Drives three memory stages (read latency 1, 3, 4) in lockstep and checks every cycle
// against a reference memory and handshake-timing model.
module tb_memory_stage_pipe;
    localparam int unsigned DEPTH = 256;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic reset;
    logic in_valid, MemReadM, MemWriteM;
    logic [15:0] addrM, write_dataM, alu_resultM;
    logic [NDUT-1:0] ordy;
    logic [NDUT-1:0] ov, ir, er;
    logic [NDUT-1:0][15:0] rd, al;

    int checks = 0;
    int failures = 0;
    int lats [NDUT] = '{1, 3, 4};

    logic [15:0] ref_mem [DEPTH];
    bit written [DEPTH];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        memory_stage_pipe_if #(.DATA_W(16), .ADDR_W(16)) bus ();
        memory_stage_pipe #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .READ_LAT(LAT)) dut (
            .clk(clk),
            .reset(reset),
            .bus(bus)
        );
        assign bus.in_valid    = in_valid;
        assign bus.MemReadM    = MemReadM;
        assign bus.MemWriteM   = MemWriteM;
        assign bus.addrM       = addrM;
        assign bus.write_dataM = write_dataM;
        assign bus.alu_resultM = alu_resultM;
        assign bus.out_ready   = ordy[g];
        assign ov[g] = bus.out_valid;
        assign ir[g] = bus.in_ready;
        assign er[g] = bus.access_err;
        assign rd[g] = bus.MemReadDataW;
        assign al[g] = bus.alu_resultW;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("%s d%0d out_valid", tag, d), ov[d], 1'b0);
            chk($sformatf("%s d%0d in_ready", tag, d), ir[d], 1'b1);
            chk($sformatf("%s d%0d rdata", tag, d), rd[d], 16'h0);
            chk($sformatf("%s d%0d alu", tag, d), al[d], 16'h0);
            chk($sformatf("%s d%0d err", tag, d), er[d], 1'b0);
        end
    endtask

    // One operation issued to all DUTs; hold = cycles of out_ready=0 after out_valid rises.
    task automatic do_op(input logic wr, input logic rdf, input logic [15:0] a,
                         input logic [15:0] wd, input logic [15:0] alu, input int hold);
        logic is_ld, oor, exp_v;
        logic [15:0] exp_rd;
        int lat [NDUT];
        is_ld  = rdf && !wr;
        oor    = (a >= 16'(DEPTH));
        exp_rd = (is_ld && !oor) ? ref_mem[a[7:0]] : 16'h0;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("pre-accept d%0d in_ready", d), ir[d], 1'b1);
            lat[d] = is_ld ? lats[d] : 1;
        end
        in_valid = 1'b1; MemWriteM = wr; MemReadM = rdf;
        addrM = a; write_dataM = wd; alu_resultM = alu;
        @(posedge clk);
        if (wr && !oor) begin
            ref_mem[a[7:0]] = wd;
            written[a[7:0]] = 1'b1;
        end
        for (int k = 1; k <= 5 + hold; k++) begin
            @(negedge clk);
            if (k == 1) begin
                in_valid = 1'b0;
                MemWriteM = 1'($urandom); MemReadM = 1'($urandom);
                addrM = 16'($urandom); write_dataM = 16'($urandom); alu_resultM = 16'($urandom);
            end
            for (int d = 0; d < NDUT; d++) begin
                exp_v = (k >= lat[d]) && (k <= lat[d] + hold);
                chk($sformatf("a=%0h d%0d k%0d out_valid", a, d, k), ov[d], exp_v);
                chk($sformatf("a=%0h d%0d k%0d in_ready", a, d, k), ir[d], k > lat[d] + hold);
                if (exp_v) begin
                    chk($sformatf("a=%0h d%0d k%0d rdata", a, d, k), rd[d], exp_rd);
                    chk($sformatf("a=%0h d%0d k%0d alu", a, d, k), al[d], alu);
                    chk($sformatf("a=%0h d%0d k%0d err", a, d, k), er[d], oor);
                end
                ordy[d] = (k >= lat[d] + hold);
            end
        end
    endtask

    initial begin
        logic [15:0] a;
        int op;
        reset = 1'b1; in_valid = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
        addrM = '0; write_dataM = '0; alu_resultM = '0; ordy = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        reset = 1'b0;

        // store then load, read-after-write at each latency
        do_op(1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h1111, 0);
        do_op(1'b0, 1'b1, 16'h0010, 16'h0000, 16'h2222, 0);
        do_op(1'b1, 1'b0, 16'h0020, 16'h1234, 16'h3333, 0);
        do_op(1'b0, 1'b1, 16'h0020, 16'h0000, 16'h4444, 0);
        // out-of-range store must not alias onto word 0
        do_op(1'b1, 1'b0, 16'h0000, 16'h0A0A, 16'h0001, 0);
        do_op(1'b1, 1'b0, 16'h0100, 16'h5555, 16'h0002, 0);
        do_op(1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0003, 0);
        do_op(1'b0, 1'b1, 16'hFF00, 16'h0000, 16'h0004, 1);
        // pass-through, both-flags (store wins), backpressure
        do_op(1'b0, 1'b0, 16'h0030, 16'h9999, 16'h00A5, 0);
        do_op(1'b1, 1'b1, 16'h0030, 16'h6789, 16'h0005, 2);
        do_op(1'b0, 1'b1, 16'h0030, 16'h0000, 16'h0006, 5);

        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 3));
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(DEPTH, 65535))
                                            : 16'($urandom_range(0, 47));
            if (op == 1 && a < 16'(DEPTH) && !written[a[7:0]]) op = 0;
            do_op(op == 0 || op == 3, op == 1 || op == 3, a, 16'($urandom), 16'($urandom),
                  int'($urandom_range(0, 3)));
        end

        // reset one cycle after a load accept, with a store request held during reset
        ordy = '0;
        @(negedge clk);
        in_valid = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; addrM = 16'h0010;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) chk($sformatf("pre-reset d%0d out_valid", d), ov[d], d == 0);
        reset = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b1; write_dataM = 16'hDEAD;
        alu_resultM = 16'h7777;
        repeat (2) begin
            @(negedge clk);
            chk_idle_outputs("in-reset");
        end
        reset = 1'b0; in_valid = 1'b0; ordy = '1;
        repeat (6) begin
            @(negedge clk);
            chk_idle_outputs("post-reset");
        end
        do_op(1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0BAD, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
